// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg: shared FSM state encoding and bus direction constants
package bus_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, FINISH} state_t;
  localparam logic BUS_RD = 1'b0;
  localparam logic BUS_WR = 1'b1;
endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// bus_arbiter_rr_pick: combinational round-robin priority encoder starting at ptr
module bus_arbiter_rr_pick #(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  logic [IW-1:0] j;
  always_comb begin
    idx = '0;
    j = '0;
    any = |req;
    for (int i = N - 1; i >= 0; i--) begin
      j = IW'((int'(ptr) + i) % N);
      idx = req[j] ? j : idx;
    end
    gnt = '0;
    gnt[idx] = any;
  end
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin single-owner memory bus arbiter and read/write sequencer
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TMO_CYC = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        req_we,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_wdata,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        done,
  output logic [NREQ-1:0]        err,
  output logic [DATA_W-1:0]      rdata,
  output logic                   bus_busy,
  output logic [ADDR_W-1:0]      addr,
  output logic [DATA_W-1:0]      data_out,
  input  logic [DATA_W-1:0]      data_in,
  output logic                   read_q,
  output logic                   write_q,
  input  logic                   read_dn,
  input  logic                   write_dn
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TMO_CYC + 1);
  state_t state;
  logic [IW-1:0] rr_ptr, owner, pick_idx;
  logic [NREQ-1:0] pick_gnt;
  logic pick_any, we, dn;
  logic [CW-1:0] cnt;
  bus_arbiter_rr_pick #(.N(NREQ), .IW(IW)) u_pick (
    .req(req),
    .ptr(rr_ptr),
    .gnt(pick_gnt),
    .idx(pick_idx),
    .any(pick_any)
  );
  assign dn = (we == BUS_WR) ? write_dn : read_dn;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      owner <= '0;
      we <= BUS_RD;
      cnt <= '0;
      gnt <= '0;
      done <= '0;
      err <= '0;
      read_q <= 1'b0;
      write_q <= 1'b0;
      bus_busy <= 1'b0;
      addr <= '0;
      data_out <= '0;
      rdata <= '0;
    end else begin
      case (state)
        IDLE: if (pick_any) begin
          owner <= pick_idx;
          we <= req_we[pick_idx];
          addr <= req_addr[pick_idx*ADDR_W +: ADDR_W];
          data_out <= req_wdata[pick_idx*DATA_W +: DATA_W];
          gnt <= pick_gnt;
          read_q <= req_we[pick_idx] == BUS_RD;
          write_q <= req_we[pick_idx] == BUS_WR;
          bus_busy <= 1'b1;
          cnt <= '0;
          state <= ACCESS;
        end
        ACCESS: if (dn) begin
          read_q <= 1'b0;
          write_q <= 1'b0;
          done[owner] <= 1'b1;
          if (we == BUS_RD) rdata <= data_in;
          state <= FINISH;
        end else if (cnt == CW'(TMO_CYC)) begin
          read_q <= 1'b0;
          write_q <= 1'b0;
          err[owner] <= 1'b1;
          state <= FINISH;
        end else begin
          cnt <= cnt + 1'b1;
        end
        FINISH: begin
          done <= '0;
          err <= '0;
          gnt <= '0;
          bus_busy <= 1'b0;
          rr_ptr <= (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
